// File: rtl/adc_sequenciador.sv
// Dual-slope ADC sequencer: auto-zero, fixed integration, timed reference de-integration, display load.
// Optional macro ADC_POLARITY_EN adds vm_neg/neg and splits ch_ref into ch_ref_p/ch_ref_n.
module adc_sequenciador #(
  parameter int CW     = 12,
  parameter int T_ZR   = 16,
  parameter int N_INT  = 1000,
  parameter int N_MAX  = 2000,
  parameter int T_HOLD = 64
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          inicio,
  input  logic          continuo,
  input  logic          vint_z,
  output logic          ch_zr,
  output logic          ch_vm,
  output logic          rst_s,
  output logic          enb_0,
  output logic          ld,
  output logic          busy,
  output logic          valid,
  output logic          ovr,
  output logic [CW-1:0] result
`ifdef ADC_POLARITY_EN
  ,
  input  logic          vm_neg,
  output logic          ch_ref_p,
  output logic          ch_ref_n,
  output logic          neg
`else
  ,
  output logic          ch_ref
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_INTEG, S_DEINT, S_LOAD, S_HOLD
  } state_t;

  localparam logic [CW-1:0] ZR_LAST   = CW'(T_ZR - 1);
  localparam logic [CW-1:0] INT_LAST  = CW'(N_INT - 1);
  localparam logic [CW-1:0] MAX_LAST  = CW'(N_MAX - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic          deint_done;

  assign deint_done = (state_reg == S_DEINT) && (state_next == S_LOAD);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Result is captured on the DEINT->LOAD edge so it is stable while valid is high.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      result <= '0;
      ovr    <= 1'b0;
    end else if (deint_done) begin
      if (vint_z) begin
        result <= timer_reg;
        ovr    <= 1'b0;
      end else begin
        result <= '1;
        ovr    <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        if (inicio) state_next = S_ZERO;
      end
      S_ZERO: begin
        if (timer_reg == ZR_LAST) begin
          state_next = S_INTEG;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_INTEG: begin
        if (timer_reg == INT_LAST) begin
          state_next = S_DEINT;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_DEINT: begin
        // Zero crossing wins over the timeout when both occur on the same edge.
        if (vint_z) begin
          state_next = S_LOAD;
        end else if (timer_reg == MAX_LAST) begin
          state_next = S_LOAD;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_LOAD: begin
        timer_next = '0;
        state_next = continuo ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!continuo) begin
          state_next = S_IDLE;
          timer_next = '0;
        end else if (timer_reg == HOLD_LAST) begin
          state_next = S_ZERO;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  logic ref_on;

  always_comb begin
    ch_zr  = 1'b0;
    ch_vm  = 1'b0;
    ref_on = 1'b0;
    rst_s  = 1'b0;
    enb_0  = 1'b0;
    ld     = 1'b0;
    valid  = 1'b0;
    busy   = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE, S_ZERO, S_HOLD: begin
        ch_zr = 1'b1;
        rst_s = 1'b1;
      end
      S_INTEG: begin
        ch_vm = 1'b1;
        enb_0 = 1'b1;
      end
      S_DEINT: begin
        ref_on = 1'b1;
        enb_0  = ~vint_z;
      end
      S_LOAD: begin
        ld    = 1'b1;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ADC_POLARITY_EN
  logic vm_neg_reg;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      vm_neg_reg <= 1'b0;
      neg        <= 1'b0;
    end else begin
      if (state_reg == S_INTEG && timer_reg == INT_LAST) vm_neg_reg <= vm_neg;
      if (deint_done) neg <= vm_neg_reg;
    end
  end

  // Reference polarity is opposite to the input so the integrator ramps back toward zero.
  assign ch_ref_p = ref_on & vm_neg_reg;
  assign ch_ref_n = ref_on & ~vm_neg_reg;
`else
  assign ch_ref = ref_on;
`endif

endmodule
